// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: flow-controlled pipeline stage register with a 2-entry skid
// buffer. A main register (M) drives the outputs and a skid register (S) absorbs
// one beat while downstream stalls. in_ready, out_valid and occupancy decode
// straight from the state register, so no ready path is combinational.
//
// Build option: define PIPE_STAGE_PERF_EN to add the saturating stall_cnt and
// flush_cnt performance counters. Without it those ports do not exist.

module pipe_stage_skid #(
    parameter int unsigned       DATA_W  = 175,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] m_d;
    logic [DATA_W-1:0] s_q;
    logic [DATA_W-1:0] s_d;
    logic              push;
    logic              pop;

    // Handshake qualifiers; both sides only see state-decoded flags.
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state_d = ST_TWO;
                    end else if (pop && !push) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Output decode from the current state only (Moore outputs).
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
        case (state_q)
            ST_EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
            ST_ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            ST_TWO: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
    end

    // Next values of the main and skid registers.
    always_comb begin
        m_d = m_q;
        s_d = s_q;
        if (flush) begin
            m_d = CLR_VAL;
            s_d = CLR_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        m_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        m_d = in_data;
                    end else if (push) begin
                        s_d = in_data;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        m_d = s_q;
                    end
                end
                default: begin
                    m_d = m_q;
                    s_d = s_q;
                end
            endcase
        end
    end

    // Data registers; M keeps its last value when draining to EMPTY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q <= CLR_VAL;
            s_q <= CLR_VAL;
        end else begin
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    assign out_data = m_q;

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating stall and flush counters; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for pipe_stage_skid. The reference is a
// bounded FIFO (capacity 2) of expected beats plus the last-presented value.
// With PIPE_STAGE_PERF_EN defined the performance counters are checked too.

module tb_pipe_stage_skid;

    localparam int unsigned DW = 175;
    localparam logic [DW-1:0] CLR = '0;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference state: accepted-but-not-delivered beats, and what out_data shows when idle.
    logic [DW-1:0] sb[$];
    logic [DW-1:0] hold_val;
    int unsigned   exp_stall;
    int unsigned   exp_flush;

    pipe_stage_skid #(.DATA_W(DW), .CLR_VAL(CLR)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [191:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return DW'(w);
    endfunction

    // Reference model: advance the FIFO at each clock edge from the applied inputs.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sb.delete();
            hold_val  = CLR;
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            automatic bit can_pop  = (sb.size() != 0) && out_ready;
            automatic bit can_push = in_valid && (sb.size() < 2);
            if ((sb.size() != 0) && !out_ready) exp_stall++;
            if (flush) exp_flush++;
            if (flush) begin
                sb.delete();
                hold_val = CLR;
            end else begin
                if (can_pop) hold_val = sb.pop_front();
                if (can_push) sb.push_back(in_data);
            end
        end
    end

    // Monitor: compare DUT outputs with the reference away from the active edge.
    always @(negedge clk) begin
        chk("out_valid", DW'(out_valid), DW'(sb.size() != 0));
        chk("in_ready", DW'(in_ready), DW'(sb.size() < 2));
        chk("occupancy", DW'(occupancy), DW'(sb.size()));
        chk("out_data", out_data, (sb.size() != 0) ? sb[0] : hold_val);
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", DW'(stall_cnt), DW'(exp_stall));
        chk("flush_cnt", DW'(flush_cnt), DW'(exp_flush));
`endif
    end

    // Apply one cycle of inputs, then move to 2 time units after the next edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        do_reset();

        // Reset asserted between edges while ONE holds 0xA5.
        step(1'b1, DW'(32'hA5), 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("async_rst_out_valid", DW'(out_valid), DW'(0));
        chk("async_rst_in_ready", DW'(in_ready), DW'(1));
        chk("async_rst_occupancy", DW'(occupancy), DW'(0));
        chk("async_rst_out_data", out_data, CLR);
        @(posedge clk);
        #2 reset = 1'b0;

        // Streaming at full throughput.
        step(1'b1, DW'(32'h1), 1'b1, 1'b0);
        step(1'b1, DW'(32'h2), 1'b1, 1'b0);
        chk("stream_out_data", out_data, DW'(32'h2));
        step(1'b1, DW'(32'h3), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("drain_hold", out_data, DW'(32'h3));

        // Back-pressure fills the skid entry, then drains in order.
        step(1'b1, DW'(32'h10), 1'b0, 1'b0);
        step(1'b1, DW'(32'h11), 1'b0, 1'b0);
        chk("bp_occupancy", DW'(occupancy), DW'(2));
        chk("bp_in_ready", DW'(in_ready), DW'(0));
        step(1'b0, '0, 1'b0, 1'b0);
        chk("bp_held", out_data, DW'(32'h10));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("bp_second", out_data, DW'(32'h11));
        chk("bp_ready_back", DW'(in_ready), DW'(1));
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush while full with a beat presented.
        step(1'b1, DW'(32'h20), 1'b0, 1'b0);
        step(1'b1, DW'(32'h21), 1'b0, 1'b0);
        step(1'b1, DW'(32'h22), 1'b0, 1'b1);
        chk("flush_occupancy", DW'(occupancy), DW'(0));
        chk("flush_out_data", out_data, CLR);
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush and push together from EMPTY, then a clean push.
        step(1'b1, DW'(32'h33), 1'b1, 1'b1);
        chk("flush_push_valid", DW'(out_valid), DW'(0));
        step(1'b1, DW'(32'h34), 1'b1, 1'b0);
        chk("after_flush_push", out_data, DW'(32'h34));
        step(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
        // Five stall cycles and two flush pulses, then reset clears both.
        do_reset();
        step(1'b1, DW'(32'h40), 1'b0, 1'b0);
        repeat (5) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("perf_stall", DW'(stall_cnt), DW'(5));
        chk("perf_flush", DW'(flush_cnt), DW'(2));
        do_reset();
        chk("perf_stall_rst", DW'(stall_cnt), DW'(0));
        chk("perf_flush_rst", DW'(flush_cnt), DW'(0));
`endif

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), rand_data(),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
